// File: rtl/mem_io_responder.sv
// CPU-side RAM plus memory-mapped UART FIFOs, cycle counter and stop flag.
// Define MEM_IO_RX_EN to build the UART receive FIFO at 0x30000.
module mem_io_responder #(
    parameter int RAM_ADDR_W = 17,
    parameter int FIFO_LOG2  = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_a,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        prog_stop
);

    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam logic [FIFO_LOG2:0] CNT_FULL = (FIFO_LOG2+1)'(DEPTH);
    localparam logic [FIFO_LOG2:0] CNT_HIGH = (FIFO_LOG2+1)'(DEPTH - 1);
    localparam logic [17:0] A_UART = 18'h30000;
    localparam logic [17:0] A_CNT0 = 18'h30004;
    localparam logic [17:0] A_CNT1 = 18'h30005;
    localparam logic [17:0] A_CNT2 = 18'h30006;
    localparam logic [17:0] A_CNT3 = 18'h30007;

    logic [17:0]           addr;
    logic                  io_sp;
    logic                  ram_hit;
    logic [RAM_ADDR_W-1:0] ram_idx;
    logic                  rd_op;
    logic                  unused_hi;

    assign addr      = cpu_a[17:0];
    assign unused_hi = &{1'b0, cpu_a[31:18]};
    assign io_sp     = (addr[17:16] == 2'b11);
    assign ram_hit   = !io_sp && ((addr >> RAM_ADDR_W) == '0);
    assign ram_idx   = addr[RAM_ADDR_W-1:0];
    assign rd_op     = !cpu_wr;

    // RAM is not reset; its read register is muxed out only for RAM reads
    logic [7:0] ram [0:(1<<RAM_ADDR_W)-1];
    logic [7:0] ram_q;

    always_ff @(posedge clk_in) begin
        if (cpu_wr && ram_hit)
            ram[ram_idx] <= cpu_dout;
        ram_q <= ram[ram_idx];
    end

    logic        rx_rd;
    logic [3:0]  cnt_rd;
    logic [7:0]  rx_byte;
    logic [7:0]  io_nxt;
    logic [7:0]  io_q;
    logic        rd_ram;
    logic [31:0] counter;
    logic [31:0] shadow;

    assign rx_rd     = rd_op && (addr == A_UART);
    assign cnt_rd[0] = rd_op && (addr == A_CNT0);
    assign cnt_rd[1] = rd_op && (addr == A_CNT1);
    assign cnt_rd[2] = rd_op && (addr == A_CNT2);
    assign cnt_rd[3] = rd_op && (addr == A_CNT3);

    // TX FIFO
    logic [7:0]           tx_mem [0:DEPTH-1];
    logic [FIFO_LOG2-1:0] tx_wp;
    logic [FIFO_LOG2-1:0] tx_rp;
    logic [FIFO_LOG2:0]   tx_cnt;
    logic                 tx_push;
    logic                 tx_pop;

    assign tx_push = cpu_wr && (addr == A_UART) && (cpu_dout != 8'h00)
                     && (tx_cnt != CNT_FULL);
    assign tx_valid       = (tx_cnt != '0);
    assign tx_pop         = tx_valid && tx_ready;
    assign tx_data        = tx_mem[tx_rp];
    assign io_buffer_full = (tx_cnt >= CNT_HIGH);

    always_ff @(posedge clk_in) begin
        if (tx_push)
            tx_mem[tx_wp] <= cpu_dout;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push)
                tx_wp <= tx_wp + 1'b1;
            if (tx_pop)
                tx_rp <= tx_rp + 1'b1;
            if (tx_push && !tx_pop)
                tx_cnt <= tx_cnt + 1'b1;
            else if (!tx_push && tx_pop)
                tx_cnt <= tx_cnt - 1'b1;
        end
    end

`ifdef MEM_IO_RX_EN
    logic [7:0]           rx_mem [0:DEPTH-1];
    logic [FIFO_LOG2-1:0] rx_wp;
    logic [FIFO_LOG2-1:0] rx_rp;
    logic [FIFO_LOG2:0]   rx_cnt;
    logic                 rx_push;
    logic                 rx_pop;

    assign rx_ready = (rx_cnt != CNT_FULL);
    assign rx_push  = rx_valid && rx_ready;
    assign rx_pop   = rx_rd && (rx_cnt != '0);
    assign rx_byte  = (rx_cnt != '0) ? rx_mem[rx_rp] : 8'h00;

    always_ff @(posedge clk_in) begin
        if (rx_push)
            rx_mem[rx_wp] <= rx_data;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push)
                rx_wp <= rx_wp + 1'b1;
            if (rx_pop)
                rx_rp <= rx_rp + 1'b1;
            if (rx_push && !rx_pop)
                rx_cnt <= rx_cnt + 1'b1;
            else if (!rx_push && rx_pop)
                rx_cnt <= rx_cnt - 1'b1;
        end
    end
`else
    logic unused_rx;

    assign unused_rx = &{1'b0, rx_valid, rx_data};
    assign rx_ready  = 1'b0;
    assign rx_byte   = 8'h00;
`endif

    // Byte 0 returns the live counter, which is also what the shadow latches
    always_comb begin
        io_nxt = 8'h00;
        unique case (1'b1)
            rx_rd:     io_nxt = rx_byte;
            cnt_rd[0]: io_nxt = counter[7:0];
            cnt_rd[1]: io_nxt = shadow[15:8];
            cnt_rd[2]: io_nxt = shadow[23:16];
            cnt_rd[3]: io_nxt = shadow[31:24];
            default:   io_nxt = 8'h00;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            io_q      <= 8'h00;
            rd_ram    <= 1'b0;
            counter   <= '0;
            shadow    <= '0;
            prog_stop <= 1'b0;
        end else begin
            io_q    <= io_nxt;
            rd_ram  <= rd_op && ram_hit;
            counter <= counter + 32'd1;
            if (cnt_rd[0])
                shadow <= counter;
            if (cpu_wr && (addr == A_CNT0))
                prog_stop <= 1'b1;
        end
    end

    assign cpu_din = rd_ram ? ram_q : io_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: vector table for the RAM/IO map,
// hand sequences for the FIFOs, counter snapshot and reset behaviour.
module tb_mem_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] cpu_a;
    logic        cpu_wr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        prog_stop;

    mem_io_responder dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .cpu_a          (cpu_a),
        .cpu_wr         (cpu_wr),
        .cpu_dout       (cpu_dout),
        .cpu_din        (cpu_din),
        .io_buffer_full (io_buffer_full),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_ready       (rx_ready),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .prog_stop      (prog_stop)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] a;
        logic        wr;
        logic [7:0]  d;
        logic        chk;
        logic [7:0]  exp;
    } vec_t;

    int          nvec = 0;
    int          nerr = 0;
    logic [7:0]  rd_q [$];
    logic [7:0]  tx_q [$];
    int          rx_cnt;
    logic        exp_stop;
    logic [31:0] cnt_m;
    logic [31:0] snap;
    vec_t        vt [16];

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One bus cycle: drive at negedge, update model at posedge, check at negedge
    task automatic step(input logic [31:0] a, input logic wr,
                        input logic [7:0] d, input logic chk,
                        input logic [7:0] exp, input string nm);
        int old;
        logic [7:0] e;
        cpu_a    = a;
        cpu_wr   = wr;
        cpu_dout = d;
        if (chk)
            rd_q.push_back(exp);
        @(posedge clk_in);
        old = tx_q.size();
        if (tx_ready && old != 0)
            tx_q.delete(0);
        if (wr && a[17:0] == 18'h30000 && d != 8'h00 && old < 16)
            tx_q.push_back(d);
        if (wr && a[17:0] == 18'h30004)
            exp_stop = 1'b1;
        old = rx_cnt;
`ifdef MEM_IO_RX_EN
        if (rx_valid && old < 16)
            rx_cnt++;
        if (!wr && a[17:0] == 18'h30000 && old != 0)
            rx_cnt--;
`endif
        cnt_m++;
        @(negedge clk_in);
        if (chk) begin
            e = rd_q.pop_front();
            cmp(nm, cpu_din, e);
        end
        cmp({nm, ".tx_valid"}, tx_valid, tx_q.size() != 0);
        if (tx_q.size() != 0)
            cmp({nm, ".tx_data"}, tx_data, tx_q[0]);
        cmp({nm, ".io_buffer_full"}, io_buffer_full, tx_q.size() >= 15);
        cmp({nm, ".prog_stop"}, prog_stop, exp_stop);
`ifdef MEM_IO_RX_EN
        cmp({nm, ".rx_ready"}, rx_ready, rx_cnt < 16);
`else
        cmp({nm, ".rx_ready"}, rx_ready, 1'b0);
`endif
    endtask

    task automatic idle();
        step(32'h0, 1'b0, 8'h00, 1'b0, 8'h00, "idle");
    endtask

    task automatic do_reset();
        rst_in   = 1'b1;
        cpu_wr   = 1'b0;
        cpu_a    = 32'h0;
        rx_valid = 1'b0;
        #1;
        cmp("rst.cpu_din", cpu_din, 8'h00);
        cmp("rst.prog_stop", prog_stop, 1'b0);
        cmp("rst.tx_valid", tx_valid, 1'b0);
        cmp("rst.io_buffer_full", io_buffer_full, 1'b0);
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        tx_q.delete();
        rd_q.delete();
        rx_cnt   = 0;
        exp_stop = 1'b0;
        cnt_m    = '0;
    endtask

    initial begin
        rst_in   = 1'b1;
        cpu_a    = '0;
        cpu_wr   = 1'b0;
        cpu_dout = '0;
        rx_valid = 1'b0;
        rx_data  = '0;
        tx_ready = 1'b0;
        rx_cnt   = 0;
        exp_stop = 1'b0;
        cnt_m    = '0;

        vt[0]  = '{32'h00000123, 1'b1, 8'hA5, 1'b0, 8'h00};
        vt[1]  = '{32'h00000123, 1'b0, 8'h00, 1'b1, 8'hA5};
        vt[2]  = '{32'h00000000, 1'b1, 8'h11, 1'b0, 8'h00};
        vt[3]  = '{32'h0001FFFF, 1'b1, 8'h5A, 1'b0, 8'h00};
        vt[4]  = '{32'h00020000, 1'b1, 8'h77, 1'b0, 8'h00};
        vt[5]  = '{32'h00020000, 1'b0, 8'h00, 1'b1, 8'h00};
        vt[6]  = '{32'h00000000, 1'b0, 8'h00, 1'b1, 8'h11};
        vt[7]  = '{32'h0001FFFF, 1'b0, 8'h00, 1'b1, 8'h5A};
        vt[8]  = '{32'h00030008, 1'b1, 8'h99, 1'b0, 8'h00};
        vt[9]  = '{32'h00030008, 1'b0, 8'h00, 1'b1, 8'h00};
        vt[10] = '{32'h00030001, 1'b0, 8'h00, 1'b1, 8'h00};
        vt[11] = '{32'h00030000, 1'b0, 8'h00, 1'b1, 8'h00};
        vt[12] = '{32'hFFF00123, 1'b0, 8'h00, 1'b1, 8'hA5};
        vt[13] = '{32'h00010123, 1'b1, 8'h3C, 1'b0, 8'h00};
        vt[14] = '{32'h00000123, 1'b0, 8'h00, 1'b1, 8'hA5};
        vt[15] = '{32'h00010123, 1'b0, 8'h00, 1'b1, 8'h3C};

        @(negedge clk_in);
        do_reset();

        for (int i = 0; i < 16; i++)
            step(vt[i].a, vt[i].wr, vt[i].d, vt[i].chk, vt[i].exp,
                 $sformatf("vec%0d", i));

        // TX ordering with a zero byte skipped, then drain
        do_reset();
        tx_ready = 1'b0;
        step(32'h30000, 1'b1, 8'h41, 1'b0, 8'h00, "tx_w41");
        step(32'h30000, 1'b1, 8'h00, 1'b0, 8'h00, "tx_w00");
        step(32'h30000, 1'b1, 8'h42, 1'b0, 8'h00, "tx_w42");
        idle();
        tx_ready = 1'b1;
        step(32'h0, 1'b0, 8'h00, 1'b0, 8'h00, "tx_pop1");
        step(32'h0, 1'b0, 8'h00, 1'b0, 8'h00, "tx_pop2");
        tx_ready = 1'b0;

        // TX fill: nearly-full at 15, 16th accepted, 17th dropped
        do_reset();
        for (int i = 0; i < 17; i++)
            step(32'h30000, 1'b1, 8'(i + 1), 1'b0, 8'h00,
                 $sformatf("fill%0d", i + 1));
        tx_ready = 1'b1;
        for (int i = 0; i < 17; i++)
            step(32'h0, 1'b0, 8'h00, 1'b0, 8'h00, $sformatf("drain%0d", i));
        tx_ready = 1'b0;

        // RX path
        do_reset();
        rx_valid = 1'b1;
        rx_data  = 8'h31;
        idle();
        rx_data  = 8'h32;
        idle();
        rx_valid = 1'b0;
`ifdef MEM_IO_RX_EN
        step(32'h30000, 1'b0, 8'h00, 1'b1, 8'h31, "rx_rd1");
        step(32'h30000, 1'b0, 8'h00, 1'b1, 8'h32, "rx_rd2");
        step(32'h30000, 1'b0, 8'h00, 1'b1, 8'h00, "rx_rd3");
        rx_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            rx_data = 8'(8'h50 + i);
            idle();
        end
        rx_valid = 1'b0;
        step(32'h30000, 1'b0, 8'h00, 1'b1, 8'h50, "rx_full_rd");
        step(32'h30000, 1'b0, 8'h00, 1'b1, 8'h51, "rx_full_rd2");
`else
        step(32'h30000, 1'b0, 8'h00, 1'b1, 8'h00, "rx_off_rd");
`endif

        // Counter snapshot 100 cycles after reset
        do_reset();
        repeat (100) idle();
        snap = cnt_m;
        step(32'h30004, 1'b0, 8'h00, 1'b1, snap[7:0], "cnt_b0");
        step(32'h30005, 1'b0, 8'h00, 1'b1, snap[15:8], "cnt_b1");
        step(32'h30006, 1'b0, 8'h00, 1'b1, snap[23:16], "cnt_b2");
        step(32'h30007, 1'b0, 8'h00, 1'b1, snap[31:24], "cnt_b3");
        cmp("cnt_snap100", snap, 32'd100);
        repeat (200) idle();
        snap = cnt_m;
        step(32'h30004, 1'b0, 8'h00, 1'b1, snap[7:0], "cnt2_b0");
        repeat (3) idle();
        step(32'h30005, 1'b0, 8'h00, 1'b1, snap[15:8], "cnt2_b1");

        // Sticky stop flag, then asynchronous mid-cycle reset
        step(32'h30000, 1'b1, 8'h7E, 1'b0, 8'h00, "stop_tx");
        step(32'h30004, 1'b1, 8'h00, 1'b0, 8'h00, "stop_w");
        repeat (3) idle();
        step(32'h00000123, 1'b0, 8'h00, 1'b1, 8'hA5, "pre_rst_rd");
        cpu_a  = 32'h00000123;
        cpu_wr = 1'b0;
        #2;
        rst_in = 1'b1;
        #1;
        cmp("midrst.prog_stop", prog_stop, 1'b0);
        cmp("midrst.tx_valid", tx_valid, 1'b0);
        cmp("midrst.cpu_din", cpu_din, 8'h00);
        cmp("midrst.io_buffer_full", io_buffer_full, 1'b0);
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        tx_q.delete();
        rd_q.delete();
        rx_cnt   = 0;
        exp_stop = 1'b0;
        cnt_m    = '0;
        step(32'h00000123, 1'b0, 8'h00, 1'b1, 8'hA5, "ram_kept");
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mem_io_responder.md
MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 SHALL expose parameters, one per line: name, default, meaning.
- RAM_ADDR_W, 17, RAM byte-address width (2^17 = 128 KiB).
- FIFO_LOG2, 4, log2 depth of each UART byte FIFO (depth 16).
REQ-002 SHALL expose ports, one per line: name, direction, width, meaning.
- clk_in, input, 1, single system clock; all state on rising edge.
- rst_in, input, 1, asynchronous active-high reset.
- cpu_a, input, 32, CPU address bus; only [17:0] decoded.
- cpu_wr, input, 1, 1 = write, 0 = read, every cycle.
- cpu_dout, input, 8, CPU write data.
- cpu_din, output, 8, read data to CPU, registered.
- io_buffer_full, output, 1, TX FIFO nearly full; CPU stalls on it.
- rx_valid, input, 1, UART receive byte offered.
- rx_data, input, 8, UART receive byte.
- rx_ready, output, 1, RX FIFO can accept.
- tx_valid, output, 1, TX FIFO non-empty.
- tx_data, output, 8, TX FIFO head byte.
- tx_ready, input, 1, UART transmitter accepts head.
- prog_stop, output, 1, sticky program-stop flag.

Function
REQ-003 SHALL decode cpu_a[17:16]==2'b11 as IO and all else as memory space.
REQ-004 SHALL serve RAM reads with 1-cycle latency: address at edge N, byte on cpu_din after edge N+1.
REQ-005 SHALL commit RAM writes at the edge where cpu_wr=1; a read of the same address next cycle returns the new byte.
REQ-006 SHALL return 0x00 for reads of addresses >= 2^RAM_ADDR_W outside IO space, and ignore writes to them.
REQ-007 SHALL, on a read of 0x30000, pop the RX FIFO head into cpu_din next cycle; if the FIFO is empty, cpu_din=0x00 and nothing pops; consecutive read cycles each pop.
REQ-008 SHALL, on a write of 0x30000 with cpu_dout!=0x00, push cpu_dout to the TX FIFO; 0x00 is ignored; a write while the FIFO is full is dropped.
REQ-009 SHALL increment a 32-bit cycle counter every cycle after reset, wrapping 0xFFFFFFFF -> 0.
REQ-010 SHALL, on a read of 0x30004, latch the counter into a 32-bit shadow and return shadow[7:0] next cycle; reads of 0x30005/6/7 return shadow bytes 1/2/3 without relatching.
REQ-011 SHALL set prog_stop on any write to 0x30004; it is cleared only by reset.
REQ-012 SHALL return 0x00 for reads of other IO addresses and ignore writes to them.
REQ-013 SHALL assert io_buffer_full combinationally when TX occupancy >= 2^FIFO_LOG2 - 1, leaving one slot for an in-flight write.
REQ-014 SHALL drive tx_valid = (TX occupancy != 0), with tx_data = head; the head pops at each edge where tx_valid && tx_ready.
REQ-015 SHALL drive rx_ready = (RX occupancy < depth); a byte enqueues at each edge where rx_valid && rx_ready.
REQ-016 SHALL handle a simultaneous push and pop on one FIFO in the same cycle: occupancy unchanged when non-empty; when empty, only the push takes effect.
REQ-017 SHALL implement FIFO pointers as FIFO_LOG2-bit wrapping counters with a separate occupancy counter.

Reset
REQ-018 SHALL, while rst_in is high, force asynchronously: cpu_din=0x00, prog_stop=0, counter=0, shadow=0, both FIFOs empty, tx_valid=0.
REQ-019 SHALL NOT reset RAM contents; a reset mid-transfer discards FIFO contents and any pending read data.

Configuration
REQ-020 SHALL compile the RX path only when macro MEM_IO_RX_EN is defined.
- Defined: behaviour per REQ-007 and REQ-015.
- Undefined: no RX FIFO storage, rx_ready tied 0, reads of 0x30000 return 0x00; all other behaviour unchanged.

Verification
REQ-021 SHALL cover: write 0xA5 to 0x00123, then read 0x00123 -> cpu_din=0xA5 one cycle after the read address.
REQ-022 SHALL cover: write 0x41, 0x00, 0x42 to 0x30000 with tx_ready=0 -> occupancy 2, then tx_ready=1 -> tx_data 0x41 then 0x42.
REQ-023 SHALL cover: 15 non-zero writes to 0x30000 with tx_ready=0 -> io_buffer_full=1 after the 15th; 16th write accepted, 17th dropped.
REQ-024 SHALL cover: with MEM_IO_RX_EN defined, push 0x31, 0x32 via rx, then read 0x30000 three times -> 0x31, 0x32, 0x00.
REQ-025 SHALL cover: 100 cycles after reset, read 0x30004, 0x30005, 0x30006, 0x30007 -> 4 bytes of a single snapshot (~100), byte 1..3 = 0x00.
REQ-026 SHALL cover: write any value to 0x30004 -> prog_stop=1 held; assert rst_in mid-cycle -> prog_stop=0 and tx_valid=0 immediately.
